// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DBIT_MAX data bits, none/even/odd parity, 1/2 stop, 3-sample majority.
// Latency: rx_done_tick one clk after the s_tick that ends the last stop bit; rx falling edge to start in 2-3 clk.
// No backpressure: dout/flags hold until the next frame, so the consumer must capture them on rx_done_tick.
module uart_rx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_tick,
  input  logic                rx,
  input  logic [1:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic                rx_done_tick,
  output logic [DBIT_MAX-1:0] dout,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det
);
  localparam int SW = $clog2(OVS);
  localparam int NW = 4;
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_SMP0 = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_SMP1 = SW'(OVS / 2);
  localparam logic [SW-1:0] S_SMP2 = SW'(OVS / 2 + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_RECOV
  } state_t;

  state_t              state, state_nxt;
  logic                rx_meta, rx_s;
  logic [SW-1:0]       s;
  logic [2:0]          smp;
  logic                maj, decide;
  logic [NW-1:0]       n, nbits_l, nbits_cfg;
  logic                par_en_l, par_odd_l, stop2_l;
  logic [DBIT_MAX-1:0] sh;
  logic                dpar, zero_run, ferr_pend, perr_pend;
  logic                start_frame, shift_en, par_chk, stop_chk, finish;

  assign maj    = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign decide = s_tick && (s == S_LAST);

  // Data-bit count from config, clamped to what dout can hold.
  always_comb begin
    nbits_cfg = NW'(cfg_dbits) + NW'(5);
    if (nbits_cfg > NW'(DBIT_MAX)) nbits_cfg = NW'(DBIT_MAX);
  end

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-bit action strobes; every transition except idle/recover waits for the bit decision.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    stop_chk    = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE:  if (!rx_s) begin
                  state_nxt   = ST_START;
                  start_frame = 1'b1;
                end
      ST_START: if (decide) state_nxt = maj ? ST_IDLE : ST_DATA;
      ST_DATA:  if (decide) begin
                  shift_en = 1'b1;
                  if (n == nbits_l - NW'(1)) state_nxt = par_en_l ? ST_PAR : ST_STOP;
                end
      ST_PAR:   if (decide) begin
                  par_chk   = 1'b1;
                  state_nxt = ST_STOP;
                end
      ST_STOP:  if (decide) begin
                  stop_chk = 1'b1;
                  if (n[0] == stop2_l) begin
                    finish    = 1'b1;
                    // A low stop bit may mean a held-low line; wait for it to rise first.
                    state_nxt = (ferr_pend || !maj) ? ST_RECOV : ST_IDLE;
                  end
                end
      ST_RECOV: if (rx_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Oversampling tick counter; held at zero while idle so a tick on the falling-edge cycle is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    s <= '0;
    else if (state == ST_IDLE || state == ST_RECOV)  s <= '0;
    else if (s_tick)                                 s <= (s == S_LAST) ? '0 : s + SW'(1);
  end

  // Capture the three mid-bit samples used by the majority vote.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp <= '0;
    end else if (state != ST_IDLE && s_tick) begin
      if (s == S_SMP0) smp[0] <= rx_s;
      if (s == S_SMP1) smp[1] <= rx_s;
      if (s == S_SMP2) smp[2] <= rx_s;
    end
  end

  // Frame datapath: config latch, shift register, running parity, pending error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nbits_l   <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      n         <= '0;
      sh        <= '0;
      dpar      <= 1'b0;
      zero_run  <= 1'b0;
      ferr_pend <= 1'b0;
      perr_pend <= 1'b0;
    end else if (start_frame) begin
      nbits_l   <= nbits_cfg;
      par_en_l  <= cfg_parity == 2'b01 || cfg_parity == 2'b10;
      par_odd_l <= cfg_parity == 2'b10;
      stop2_l   <= cfg_stop2;
      n         <= '0;
      sh        <= '0;
      dpar      <= 1'b0;
      zero_run  <= 1'b1;
      ferr_pend <= 1'b0;
      perr_pend <= 1'b0;
    end else if (shift_en) begin
      sh       <= {maj, sh[DBIT_MAX-1:1]};
      dpar     <= dpar ^ maj;
      zero_run <= zero_run & ~maj;
      n        <= (n == nbits_l - NW'(1)) ? '0 : n + NW'(1);
    end else if (par_chk) begin
      perr_pend <= par_odd_l ? ~(dpar ^ maj) : (dpar ^ maj);
      zero_run  <= zero_run & ~maj;
    end else if (stop_chk) begin
      if (!maj) ferr_pend <= 1'b1;
      zero_run <= zero_run & ~maj;
      n        <= n + NW'(1);
    end
  end

  // Frame outputs: update only when a frame completes, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= finish;
      if (finish) begin
        dout       <= sh >> (NW'(DBIT_MAX) - nbits_l);
        parity_err <= perr_pend;
        frame_err  <= ferr_pend | ~maj;
        break_det  <= zero_run & ~maj;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed frames plus randomized frames against a line-level model.
module tb_uart_rx_cfg;
  localparam int OVS  = 16;
  localparam int DM   = 8;
  localparam int TDIV = 4;

  logic          clk, reset_n, s_tick, rx;
  logic [1:0]    cfg_dbits, cfg_parity;
  logic          cfg_stop2;
  logic          rx_done_tick;
  logic [DM-1:0] dout;
  logic          parity_err, frame_err, break_det;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     tcnt     = 0;
  logic   prev_done = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    longint     c;
  } pulse_t;

  pulse_t pq[$];
  pulse_t expq[$];

  uart_rx_cfg #(.DBIT_MAX(DM), .OVS(OVS)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx),
    .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_done_tick(rx_done_tick), .dout(dout), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % TDIV;
      s_tick = (tcnt == 0);
    end
  end

  // Record every completion pulse; a pulse must never last two cycles.
  always @(negedge clk) begin
    pulse_t p;
    if (rx_done_tick) begin
      p.d = dout; p.pe = parity_err; p.fe = frame_err; p.bk = break_det; p.c = cyc;
      pq.push_back(p);
      n_checks++;
      if (prev_done) begin
        n_fail++;
        $display("FAIL pulse_width: rx_done_tick high 2 cycles, required 1");
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!s_tick) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic get_pulse(output bit ok, output pulse_t p);
    ok = 1'b0;
    p  = '{d: 8'h00, pe: 1'b0, fe: 1'b0, bk: 1'b0, c: 0};
    for (int i = 0; i < 60 && !ok; i++) begin
      if (pq.size() > 0) begin
        p  = pq.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Drive one tick-aligned frame; push the model's expected result. stops[0] is the first stop bit.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] dcode, input logic [1:0] pm,
                            input logic st2, input bit par_bad, input logic [1:0] stops,
                            input int glitch_bit, input bit scramble);
    logic   line[$];
    int     nb;
    logic   dx, pbit, allz;
    pulse_t e;
    nb = int'(dcode) + 5;
    if (nb > DM) nb = DM;
    cfg_dbits = dcode; cfg_parity = pm; cfg_stop2 = st2;
    line.push_back(1'b0);
    dx = 1'b0;
    pbit = 1'b0;
    for (int i = 0; i < nb; i++) begin
      line.push_back(data[i]);
      dx ^= data[i];
    end
    if (pm == 2'd1 || pm == 2'd2) begin
      pbit = ((pm == 2'd1) ? dx : ~dx) ^ par_bad;
      line.push_back(pbit);
    end
    line.push_back(stops[0]);
    if (st2) line.push_back(stops[1]);
    allz = 1'b1;
    for (int i = 1; i < line.size(); i++) if (line[i]) allz = 1'b0;
    e.d  = data & (8'hFF >> (8 - nb));
    e.pe = (pm == 2'd1) ? (dx ^ pbit) : (pm == 2'd2) ? ~(dx ^ pbit) : 1'b0;
    e.fe = ~stops[0] | (st2 & ~stops[1]);
    e.bk = allz;
    e.c  = 0;
    expq.push_back(e);
    for (int b = 0; b < line.size(); b++) begin
      for (int k = 1; k <= OVS; k++) begin
        rx = line[b] ^ ((glitch_bit >= 0 && b == glitch_bit + 1 && k == OVS / 2 + 1) ? 1'b1 : 1'b0);
        wait_tick();
        if (scramble && b == 0 && k == 1) begin
          cfg_dbits = 2'($urandom); cfg_parity = 2'($urandom); cfg_stop2 = 1'($urandom);
        end
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx = 1'b1;
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({rx_done_tick, dout, parity_err, frame_err, break_det} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 000", {rx_done_tick, dout, parity_err, frame_err, break_det});
    end
    reset_n = 1'b1;
    repeat (3 * OVS) wait_tick();
    n_checks++;
    if ({rx_done_tick, dout, parity_err, frame_err, break_det} !== 12'h000 || pq.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs %h pulses %0d, required 000 and 0",
               {rx_done_tick, dout, parity_err, frame_err, break_det}, pq.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    pulse_t p1, p2;
    wait_tick();
    send_frame(8'hA5, 2'd3, 2'd0, 1'b0, 1'b0, 2'b11, -1, 1'b1);
    send_frame(8'h3C, 2'd3, 2'd0, 1'b0, 1'b0, 2'b11, -1, 1'b1);
    get_pulse(ok1, p1);
    get_pulse(ok2, p2);
    n_checks++;
    if (!(ok1 && ok2)) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d/%0d, required 1/1", ok1, ok2);
    end
    n_checks++;
    if (p1.d !== 8'hA5) begin n_fail++; $display("FAIL b2b_dout1: got %h, required a5", p1.d); end
    n_checks++;
    if (p2.d !== 8'h3C) begin n_fail++; $display("FAIL b2b_dout2: got %h, required 3c", p2.d); end
    n_checks++;
    if ({p1.pe, p1.fe, p1.bk, p2.pe, p2.fe, p2.bk} !== 6'b0) begin
      n_fail++; $display("FAIL b2b_flags: got %b, required 000000", {p1.pe, p1.fe, p1.bk, p2.pe, p2.fe, p2.bk});
    end
    n_checks++;
    if (p2.c - p1.c != longint'(OVS * 10 * TDIV)) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d clk, required %0d", p2.c - p1.c, OVS * 10 * TDIV);
    end
  endtask

  task automatic test_7e1();
    bit ok;
    pulse_t p;
    for (int r = 0; r < 2; r++) begin
      repeat (OVS) wait_tick();
      send_frame(8'h41, 2'd2, 2'd1, 1'b0, r[0], 2'b11, -1, 1'b1);
      get_pulse(ok, p);
      n_checks++;
      if (!ok || p.d !== 8'h41) begin
        n_fail++; $display("FAIL e71_dout%0d: got %h (pulse %0d), required 41", r, p.d, ok);
      end
      n_checks++;
      if (p.pe !== r[0] || p.fe !== 1'b0 || p.bk !== 1'b0) begin
        n_fail++; $display("FAIL e71_flags%0d: got pe=%b fe=%b bk=%b, required pe=%0d fe=0 bk=0", r, p.pe, p.fe, p.bk, r);
      end
    end
  endtask

  task automatic test_false_start();
    repeat (OVS) wait_tick();
    rx = 1'b0;
    repeat (4) wait_tick();
    rx = 1'b1;
    repeat (3 * OVS) wait_tick();
    n_checks++;
    if (pq.size() != 0 || rx_done_tick !== 1'b0) begin
      n_fail++; $display("FAIL false_start_pulse: got %0d pulses, required 0", pq.size());
    end
    n_checks++;
    if ({dout, parity_err, frame_err, break_det} !== {8'h41, 3'b100}) begin
      n_fail++; $display("FAIL false_start_hold: got %h %b%b%b, required 41 100", dout, parity_err, frame_err, break_det);
    end
  endtask

  task automatic test_5o2_frame_err();
    bit ok;
    pulse_t p;
    repeat (OVS) wait_tick();
    send_frame(8'h15, 2'd0, 2'd2, 1'b1, 1'b0, 2'b01, -1, 1'b1);
    get_pulse(ok, p);
    n_checks++;
    if (!ok || p.d !== 8'h15 || p.fe !== 1'b1 || p.pe !== 1'b0 || p.bk !== 1'b0) begin
      n_fail++; $display("FAIL o52_frame: got pulse=%0d d=%h pe=%b fe=%b bk=%b, required 1 15 0 1 0", ok, p.d, p.pe, p.fe, p.bk);
    end
    repeat (3 * OVS) wait_tick();
    n_checks++;
    if (pq.size() != 0) begin n_fail++; $display("FAIL o52_no_retrigger: got %0d pulses, required 0", pq.size()); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    pulse_t p;
    logic [7:0] d;
    d = 8'h96;
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    wait_tick();
    rx = 1'b0;
    repeat (OVS) wait_tick();
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (OVS) wait_tick();
    end
    rx = d[4];
    repeat (OVS / 2) wait_tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_done_tick, dout, parity_err, frame_err, break_det} !== 12'h000) begin
      n_fail++; $display("FAIL midreset_outputs: got %h, required 000", {rx_done_tick, dout, parity_err, frame_err, break_det});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * OVS) wait_tick();
    send_frame(8'hC3, 2'd3, 2'd0, 1'b0, 1'b0, 2'b11, -1, 1'b0);
    get_pulse(ok, p);
    n_checks++;
    if (!ok || p.d !== 8'hC3 || {p.pe, p.fe, p.bk} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_frame: got pulse=%0d d=%h flags=%b%b%b, required 1 c3 000", ok, p.d, p.pe, p.fe, p.bk);
    end
    repeat (OVS) wait_tick();
    n_checks++;
    if (pq.size() != 0) begin n_fail++; $display("FAIL midreset_extra: got %0d extra pulses, required 0", pq.size()); end
  endtask

  task automatic test_data_glitch();
    bit ok;
    pulse_t p;
    repeat (OVS) wait_tick();
    send_frame(8'h5A, 2'd3, 2'd0, 1'b0, 1'b0, 2'b11, 3, 1'b0);
    get_pulse(ok, p);
    n_checks++;
    if (!ok || p.d !== 8'h5A || {p.pe, p.fe, p.bk} !== 3'b000) begin
      n_fail++; $display("FAIL glitch_vote: got pulse=%0d d=%h flags=%b%b%b, required 1 5a 000", ok, p.d, p.pe, p.fe, p.bk);
    end
  endtask

  task automatic test_break();
    bit ok;
    pulse_t p;
    cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (OVS) wait_tick();
    rx = 1'b0;
    repeat (12 * OVS) wait_tick();
    get_pulse(ok, p);
    n_checks++;
    if (!ok || p.d !== 8'h00 || p.bk !== 1'b1 || p.fe !== 1'b1 || p.pe !== 1'b0) begin
      n_fail++; $display("FAIL break_frame: got pulse=%0d d=%h pe=%b fe=%b bk=%b, required 1 00 0 1 1", ok, p.d, p.pe, p.fe, p.bk);
    end
    n_checks++;
    if (pq.size() != 0) begin n_fail++; $display("FAIL break_held_low: got %0d extra pulses, required 0", pq.size()); end
    rx = 1'b1;
    repeat (2 * OVS) wait_tick();
    n_checks++;
    if (pq.size() != 0) begin n_fail++; $display("FAIL break_release: got %0d extra pulses, required 0", pq.size()); end
  endtask

  task automatic test_random();
    bit ok;
    pulse_t p, e;
    logic [1:0] st;
    expq.delete();
    for (int f = 0; f < 14; f++) begin
      st[0] = ($urandom_range(0, 3) != 0);
      st[1] = ($urandom_range(0, 3) != 0);
      repeat (OVS) wait_tick();
      send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), st, -1, 1'b1);
      e = expq.pop_front();
      get_pulse(ok, p);
      n_checks++;
      if (!ok || p.d !== e.d) begin
        n_fail++; $display("FAIL rand_dout[%0d]: got %h (pulse %0d), required %h", f, p.d, ok, e.d);
      end
      n_checks++;
      if ({p.pe, p.fe, p.bk} !== {e.pe, e.fe, e.bk}) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got %b%b%b, required %b%b%b", f, p.pe, p.fe, p.bk, e.pe, e.fe, e.bk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_7e1();
    test_false_start();
    test_5o2_frame_err();
    test_mid_reset();
    test_data_glitch();
    test_break();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
